pipe_exmem_hs: RTL

Parametrised EX/MEM pipeline stage for the rv32imc core, with a valid/ready handshake in both directions. It replaces a free-running EX/MEM register with one that supports back-pressure, flush and an optional 2-entry skid buffer, so the stage sustains full throughput without a combinational ready path. Writeback-data pre-selection (ALU / immediate / link address) happens at stage entry. Link address is PC+2 for compressed instructions and PC+4 otherwise.

---
 rtl/pipe_exmem_hs.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_exmem_hs.sv
// EX/MEM pipeline stage with valid/ready handshake, flush and an optional
// 2-entry skid buffer; writeback data is pre-selected as the entry is captured.
module pipe_exmem_hs #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 8,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [1:0]        in_dest_sel,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              in_compressed,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_rd_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        out_dest_sel,
    output logic [XLEN-1:0]   out_rd_write_data,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_store_data,
    output logic [4:0]        out_rd_addr,
    output logic              out_rd_we,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        dest_sel;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   store_data;
        logic [4:0]        rd_addr;
        logic              rd_we;
    } entry_t;

    entry_t          in_entry;
    logic [XLEN-1:0] link_addr;

    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;
    logic   accept;
    logic   pop;

    assign link_addr = in_pc + (in_compressed ? XLEN'(2) : XLEN'(4));

    always_comb begin
        in_entry            = '0;
        in_entry.ctrl       = in_ctrl;
        in_entry.dest_sel   = in_dest_sel;
        in_entry.pc         = in_pc;
        in_entry.store_data = in_store_data;
        in_entry.rd_addr    = in_rd_addr;
        in_entry.rd_we      = in_rd_we;
        // Loads carry the memory address in the write-data slot until MEM replaces it.
        case (in_dest_sel)
            SEL_ALU:  in_entry.wdata = in_alu_result;
            SEL_IMM:  in_entry.wdata = in_imm;
            SEL_LINK: in_entry.wdata = link_addr;
            default:  in_entry.wdata = in_alu_result;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign pop    = main_valid_q && out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            entry_t skid_q, skid_d;
            logic   skid_valid_q, skid_valid_d;

            // Ready depends only on a flop, breaking the out_ready -> in_ready path.
            assign in_ready  = !skid_valid_q;
            assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (flush_i) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (skid_valid_q) begin
                    if (pop) begin
                        main_d       = skid_q;
                        main_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    if (!main_valid_q || pop) begin
                        main_d       = in_entry;
                        main_valid_d = 1'b1;
                    end else begin
                        skid_d       = in_entry;
                        skid_valid_d = 1'b1;
                    end
                end else if (pop) begin
                    main_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    main_q       <= '0;
                    main_valid_q <= 1'b0;
                    skid_q       <= '0;
                    skid_valid_q <= 1'b0;
                end else begin
                    main_q       <= main_d;
                    main_valid_q <= main_valid_d;
                    skid_q       <= skid_d;
                    skid_valid_q <= skid_valid_d;
                end
            end
        end else begin : g_single
            assign in_ready  = !main_valid_q || out_ready;
            assign occupancy = {1'b0, main_valid_q};

            always_comb begin
                main_d       = accept ? in_entry : main_q;
                main_valid_d = flush_i ? 1'b0 : (accept || (main_valid_q && !out_ready));
            end

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    main_q       <= '0;
                    main_valid_q <= 1'b0;
                end else begin
                    main_q       <= main_d;
                    main_valid_q <= main_valid_d;
                end
            end
        end
    endgenerate

    assign out_valid         = main_valid_q;
    assign out_ctrl          = main_q.ctrl;
    assign out_dest_sel      = main_q.dest_sel;
    assign out_rd_write_data = main_q.wdata;
    assign out_pc            = main_q.pc;
    assign out_store_data    = main_q.store_data;
    assign out_rd_addr       = main_q.rd_addr;
    assign out_rd_we         = main_q.rd_we & main_valid_q;

endmodule
